// File: rtl/cpu_pkg.sv
// Shared constants for the fetch/decode sequencer: op/ext codes,
// ALU opcode class bit and the sequencer state encoding.
package cpu_pkg;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_CMP  = 4'b1011;
    localparam logic [3:0] OP_MOV  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic ALU_REG = 1'b0;
    localparam logic ALU_IMM = 1'b1;

    function automatic logic [4:0] alu_opcode(input logic cls,
                                              input logic [3:0] code);
        return {cls, code};
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: 16-bit word to datapath
// control bundle plus halt/illegal classification.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [15:0] instr_i,
    output logic [3:0]  rs_o,
    output logic [3:0]  rd_o,
    output logic [4:0]  opcode_o,
    output logic [15:0] re_o,
    output logic        ri_o,
    output logic        fe_o,
    output logic [15:0] imm_o,
    output logic        halt_o,
    output logic        illegal_o
);

    logic [3:0] op;
    logic [3:0] code;
    logic       rtype;
    logic       legal;
    logic       zext;

    always_comb begin
        op    = instr_i[15:12];
        rtype = (op == OP_R);
        code  = rtype ? instr_i[7:4] : op;
        legal = 1'b0;
        zext  = 1'b0;
        unique case (code)
            OP_AND, OP_OR, OP_XOR: begin
                legal = 1'b1;
                zext  = 1'b1;
            end
            OP_ADD, OP_SUB, OP_CMP, OP_MOV: legal = 1'b1;
            default: legal = 1'b0;
        endcase

        halt_o    = (op == OP_HALT);
        illegal_o = !legal && !halt_o;

        rs_o     = '0;
        rd_o     = '0;
        opcode_o = '0;
        re_o     = '0;
        ri_o     = 1'b0;
        fe_o     = 1'b0;
        imm_o    = '0;

        if (legal) begin
            rd_o     = instr_i[11:8];
            rs_o     = rtype ? instr_i[3:0] : 4'd0;
            ri_o     = !rtype;
            opcode_o = alu_opcode(rtype ? ALU_REG : ALU_IMM, code);
            fe_o     = (code == OP_ADD) || (code == OP_SUB)
                    || (code == OP_CMP);
            re_o     = (code == OP_CMP) ? 16'd0
                                        : (16'd1 << instr_i[11:8]);
            if (!rtype) begin
                // Logic ops take an unsigned mask, arithmetic a signed value
                imm_o = zext ? {8'h00, instr_i[7:0]}
                             : {{8{instr_i[7]}}, instr_i[7:0]};
            end
        end
    end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode sequencer: 3 cycles per instruction, registered
// control bundle driven only during EXEC.
module fetch_decode_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [3:0]        rs,
    output logic [3:0]        rd,
    output logic [4:0]        opcode,
    output logic [15:0]       re,
    output logic              ri,
    output logic              fe,
    output logic [15:0]       imm,
    output logic              halted,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;
    logic [3:0]        rs_q, rs_d, rd_q, rd_d;
    logic [4:0]        opcode_q, opcode_d;
    logic [15:0]       re_q, re_d, imm_q, imm_d;
    logic              ri_q, ri_d, fe_q, fe_d;

    logic [15:0] dec_in;
    logic [3:0]  dec_rs, dec_rd;
    logic [4:0]  dec_opcode;
    logic [15:0] dec_re, dec_imm;
    logic        dec_ri, dec_fe, dec_halt, dec_illegal;

    // Decode the memory word while it arrives, the latched word in EXEC
    assign dec_in = (state_q == ST_DECODE) ? imem_data : ir_q;

    instr_decode u_dec (
        .instr_i   (dec_in),
        .rs_o      (dec_rs),
        .rd_o      (dec_rd),
        .opcode_o  (dec_opcode),
        .re_o      (dec_re),
        .ri_o      (dec_ri),
        .fe_o      (dec_fe),
        .imm_o     (dec_imm),
        .halt_o    (dec_halt),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        halted_d  = halted_q;
        illegal_d = 1'b0;
        rs_d      = '0;
        rd_d      = '0;
        opcode_d  = '0;
        re_d      = '0;
        ri_d      = 1'b0;
        fe_d      = 1'b0;
        imm_d     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d      = imem_data;
                rs_d      = dec_rs;
                rd_d      = dec_rd;
                opcode_d  = dec_opcode;
                re_d      = dec_re;
                ri_d      = dec_ri;
                fe_d      = dec_fe;
                imm_d     = dec_imm;
                illegal_d = dec_illegal;
                halted_d  = halted_q | dec_halt;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_halt) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_d = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            rs_q      <= '0;
            rd_q      <= '0;
            opcode_q  <= '0;
            re_q      <= '0;
            ri_q      <= 1'b0;
            fe_q      <= 1'b0;
            imm_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            rs_q      <= rs_d;
            rd_q      <= rd_d;
            opcode_q  <= opcode_d;
            re_q      <= re_d;
            ri_q      <= ri_d;
            fe_q      <= fe_d;
            imm_q     <= imm_d;
        end
    end

    assign imem_addr = pc_q;
    assign rs        = rs_q;
    assign rd        = rd_q;
    assign opcode    = opcode_q;
    assign re        = re_q;
    assign ri        = ri_q;
    assign fe        = fe_q;
    assign imm       = imm_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule
